// File: rtl/preg_freelist.sv
// Physical-register free list for rename: circular buffer of free preg ids
// with speculative head, committed head (flush restore) and release tail.
//
// Ports:
//   clk_i, rst_i          clock, async active-high reset
//   alloc_req_i           per-lane allocation request mask
//   alloc_ok_o            enough free ids for popcount(alloc_req_i)
//   alloc_prd_o           id per requesting lane, lane k at [k*PB +: PB]
//   commit_i              popcount = oldest allocations retired this cycle
//   rel_valid_i/rel_prd_i ids returned to the list, ascending lane order
//   flush_i               discard all uncommitted allocations
//   free_cnt_o, empty_o   speculative free count, and count == 0
//   err_o                 sticky protocol error
module preg_freelist #(
    parameter int NUM_PREGS = 16,
    parameter int PB        = $clog2(NUM_PREGS),
    parameter int RESERVED  = 1,
    parameter int ALLOC_W   = 2,
    parameter int REL_W     = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [ALLOC_W-1:0]    alloc_req_i,
    output logic                  alloc_ok_o,
    output logic [ALLOC_W*PB-1:0] alloc_prd_o,
    input  logic [ALLOC_W-1:0]    commit_i,
    input  logic [REL_W-1:0]      rel_valid_i,
    input  logic [REL_W*PB-1:0]   rel_prd_i,
    input  logic                  flush_i,
    output logic [PB:0]           free_cnt_o,
    output logic                  empty_o,
    output logic                  err_o
);

    localparam int CW = PB + 1;
    localparam logic [CW-1:0] FREE0 = CW'(NUM_PREGS - RESERVED);
    localparam logic [CW-1:0] CAP   = CW'(NUM_PREGS);

    logic [PB-1:0] fifo_q [NUM_PREGS];
    logic [PB-1:0] fifo_d [NUM_PREGS];
    logic [CW-1:0] spec_q, spec_d;
    logic [CW-1:0] cmt_q, cmt_d;
    logic [CW-1:0] tail_q, tail_d;
    logic          err_q, err_d;

    logic [CW-1:0] n_alloc, n_cmt;
    logic [CW-1:0] free_cnt, inflight, held;
    logic [CW-1:0] rptr, wptr;
    logic          grant;

    // Lane popcounts
    always_comb begin
        n_alloc = '0;
        for (int k = 0; k < ALLOC_W; k++)
            n_alloc = n_alloc + CW'(alloc_req_i[k]);
        n_cmt = '0;
        for (int k = 0; k < ALLOC_W; k++)
            n_cmt = n_cmt + CW'(commit_i[k]);
    end

    // Pointer difference is exact thanks to the wrap bit
    assign free_cnt   = tail_q - spec_q;
    assign free_cnt_o = free_cnt;
    assign empty_o    = (free_cnt == '0);
    assign alloc_ok_o = (free_cnt >= n_alloc);
    assign err_o      = err_q;

    // Compact requesting lanes onto consecutive entries from spec_head
    always_comb begin
        alloc_prd_o = '0;
        rptr        = spec_q;
        for (int k = 0; k < ALLOC_W; k++) begin
            if (alloc_req_i[k]) begin
                alloc_prd_o[k*PB +: PB] = fifo_q[rptr[PB-1:0]];
                rptr = rptr + CW'(1);
            end
        end
    end

    // Releases append at tail, valid lanes packed in ascending order
    always_comb begin
        fifo_d = fifo_q;
        wptr   = tail_q;
        for (int k = 0; k < REL_W; k++) begin
            if (rel_valid_i[k]) begin
                fifo_d[wptr[PB-1:0]] = rel_prd_i[k*PB +: PB];
                wptr = wptr + CW'(1);
            end
        end
        tail_d = wptr;
    end

    assign grant = (n_alloc != '0) && alloc_ok_o && !flush_i;

    // Flush rewinds to the commit head as updated this same cycle
    always_comb begin
        cmt_d    = cmt_q + n_cmt;
        spec_d   = flush_i ? cmt_d
                           : spec_q + (grant ? n_alloc : '0);
        inflight = spec_q - cmt_q;
        held     = tail_d - cmt_d;
        err_d    = err_q | (n_cmt > inflight) | (held > CAP);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_PREGS; i++)
                fifo_q[i] <= (i < NUM_PREGS - RESERVED) ?
                             PB'(RESERVED + i) : '0;
            spec_q <= '0;
            cmt_q  <= '0;
            tail_q <= FREE0;
            err_q  <= 1'b0;
        end else begin
            fifo_q <= fifo_d;
            spec_q <= spec_d;
            cmt_q  <= cmt_d;
            tail_q <= tail_d;
            err_q  <= err_d;
        end
    end

endmodule

// File: doc/preg_freelist.md
Name: preg_freelist

Overview:
- Parametrised physical-register free list for the rename stage.
- Hands out up to ALLOC_W preg ids per cycle to renamed instructions (di_t.prd).
- Takes back up to REL_W retired old-prd ids per cycle.
- Keeps a committed head pointer so a flush restores every speculatively allocated id in one cycle.

Parameters:
- NUM_PREGS, 16, number of physical registers (PRFSIZE); power of two.
- PB, $clog2(NUM_PREGS), preg id width (PREG_ID_BITS).
- RESERVED, 1, ids 0..RESERVED-1 are mapped at reset and are not in the list.
- ALLOC_W, 2, allocation lanes per cycle.
- REL_W, 2, release lanes per cycle.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-high
- alloc_req_i  in  ALLOC_W  per-lane allocation request mask
- alloc_ok_o  out  1  enough free ids for popcount(alloc_req_i)
- alloc_prd_o  out  ALLOC_W*PB  id given to each requesting lane; lane k occupies bits [k*PB +: PB]
- commit_i  in  ALLOC_W  mask; popcount = oldest in-flight allocations retired this cycle
- rel_valid_i  in  REL_W  per-lane release valid
- rel_prd_i  in  REL_W*PB  ids returned to the list
- flush_i  in  1  discard all uncommitted allocations
- free_cnt_o  out  PB+1  speculative free count (tail - spec_head)
- empty_o  out  1  free_cnt_o == 0
- err_o  out  1  sticky protocol error

Behaviour:
- Clock and reset: one clock clk_i; reset rst_i is asynchronous and active-high.
- Storage: circular buffer of NUM_PREGS entries of PB bits.
- Pointers: spec_head, commit_head and tail, each PB+1 bits including a wrap bit. Index is the low PB bits; counts are modulo-2^(PB+1) differences.
- Reset values:
  - entry i = RESERVED+i for i < NUM_PREGS-RESERVED; all other entries 0.
  - spec_head = commit_head = 0; tail = NUM_PREGS-RESERVED.
  - err_o = 0; free_cnt_o = NUM_PREGS-RESERVED; empty_o = 0 unless RESERVED = NUM_PREGS.
- Allocation (combinational outputs, same cycle):
  - n = popcount(alloc_req_i); alloc_ok_o = (free_cnt_o >= n); n = 0 gives alloc_ok_o = 1.
  - Requesting lanes are compacted in ascending lane order: the j-th set lane receives entry[spec_head+j].
  - Lanes with req = 0 drive 0.
  - alloc_prd_o is don't-care when alloc_ok_o = 0.
- Allocation (state update):
  - If n > 0, alloc_ok_o = 1 and flush_i = 0, spec_head += n at the clock edge.
  - Otherwise nothing is consumed. Allocation is all-or-nothing: no partial grant.
- Release:
  - Valid lanes are written in ascending lane order at entry[tail+j]; tail += popcount(rel_valid_i).
  - Released ids become allocatable the next cycle; there is no same-cycle bypass into alloc_ok_o or alloc_prd_o.
- Commit:
  - commit_head += popcount(commit_i).
  - The caller never commits more than spec_head - commit_head.
- Flush:
  - After the commit update of the same cycle, spec_head <- new commit_head.
  - Allocation requests in the flush cycle are ignored.
  - Releases in the flush cycle are accepted normally.
- Simultaneous events: alloc, commit and release in one cycle all apply independently, using pre-edge pointer values.
- Wrap-around: indices wrap modulo NUM_PREGS; the wrap bit distinguishes full from empty.
- err_o is set (and held until reset) when either:
  - commit_i count > spec_head - commit_head (pre-edge); or
  - after release, tail - commit_head > NUM_PREGS.
- On error, the state update still happens as specified and the result is undefined.
- Reset mid-operation: asynchronous return to the reset values, whatever the traffic on the inputs.
- No other pipeline latency: alloc outputs are combinational from state and alloc_req_i; every state change is visible the cycle after the edge.

Test Plan:
- Reset, defaults (NUM_PREGS=16, RESERVED=1): free_cnt_o=15, empty_o=0, err_o=0; alloc_req_i=2'b11 -> alloc_ok_o=1, alloc_prd_o lane0=1, lane1=2; next cycle free_cnt_o=13.
- Compaction: alloc_req_i=2'b10 right after reset -> lane1=1, lane0=0; next alloc_req_i=2'b11 -> lane0=2, lane1=3.
- Exhaust: 7 cycles of 2'b11 then 2'b01 -> free_cnt_o=0, empty_o=1; alloc_req_i=2'b01 -> alloc_ok_o=0 and spec_head unchanged. Same cycle release id 5 -> alloc_ok_o still 0; next cycle alloc_ok_o=1 and lane0=5.
- Flush restore: allocate ids 1..4, commit_i=2'b11 once, then flush_i=1 together with alloc_req_i=2'b11 -> no allocation; next cycle free_cnt_o=13 and the next allocation returns id 3.
- Wrap: allocate and commit all 15 ids, release ids 1..15 over 8 cycles -> tail wraps past index 15, free_cnt_o=15; next allocation returns 1 then 2 in release order.
- Error: commit_i=2'b01 with nothing in flight -> err_o=1 next cycle and it stays 1; assert rst_i mid-burst -> err_o=0, free_cnt_o=15 immediately, without waiting for a clock edge.
